// File: rtl/teclado_pkg.sv
// -----------------------------------------------------------------------------
// teclado_pkg
//   Shared definitions for the keypad number-capture path.
//   - Key codes produced by the debounced scanner (registro).
//   - FSM state encoding for captura_numero.
//   - es_digito(): true for codes 0-9.
// -----------------------------------------------------------------------------
package teclado_pkg;

   localparam logic [3:0] TECLA_NINGUNA = 4'hF;  // no key pressed
   localparam logic [3:0] TECLA_ENTER   = 4'hA;  // submit the number
   localparam logic [3:0] TECLA_CLEAR   = 4'hB;  // discard the partial entry

   typedef enum logic {
      S_CAPTURA = 1'b0,  // collecting digits
      S_ENTREGA = 1'b1   // number offered downstream, waiting for listo
   } estado_captura_t;

   function automatic logic es_digito(input logic [3:0] codigo);
      return (codigo <= 4'd9);
   endfunction

endpackage : teclado_pkg

// File: rtl/detector_tecla.sv
// -----------------------------------------------------------------------------
// detector_tecla
//   Converts the level-style key code from the scanner into a single-cycle
//   key event. An event fires on the cycle after boton leaves TECLA_NINGUNA;
//   the detector then stays disarmed until boton is seen back at
//   TECLA_NINGUNA, so a held key or a code change without release is
//   never a second event.
// Ports
//   clk     in   clock, posedge
//   rst     in   asynchronous reset, active low (comes up armed)
//   boton   in   [3:0] key code, 4'hF = no key
//   evento  out  one-cycle pulse per press
//   codigo  out  [3:0] code captured with the event, valid while evento=1
// -----------------------------------------------------------------------------
module detector_tecla
   import teclado_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] boton,
   output logic       evento,
   output logic [3:0] codigo
);

   logic armado;  // 1 = key released, next non-F code is a new press

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the clock edge, independent of order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armado <= 1'b1;
         evento <= 1'b0;
         codigo <= TECLA_NINGUNA;
      end else begin
         evento <= armado && (boton != TECLA_NINGUNA);
         if (armado && (boton != TECLA_NINGUNA)) begin
            codigo <= boton;
            armado <= 1'b0;
         end else if (boton == TECLA_NINGUNA) begin
            armado <= 1'b1;
         end
      end
   end

endmodule : detector_tecla

// File: rtl/captura_numero.sv
// -----------------------------------------------------------------------------
// captura_numero
//   Builds a multi-digit decimal number from keypad presses: one digit per
//   press, ENTER submits, CLEAR restarts. The result is offered as packed BCD
//   plus binary on a valid/ready handshake and held until accepted.
//
//   Optional feature, macro CAPTURA_TIMEOUT_EN: a partial entry left idle for
//   TIMEOUT_CYC cycles is cleared automatically. Without the macro a partial
//   entry persists and TIMEOUT_CYC only takes part in the parameter check.
//
// Parameters
//   N_DIG        max digits accepted (1..6)
//   W_BIN        binary width, >= ceil(log2(10**N_DIG))
//   TIMEOUT_CYC  idle cycles before auto-clear
// Ports
//   clk          in   clock, posedge
//   rst          in   asynchronous reset, active low
//   boton        in   [3:0] key code: 0-9 digit, A ENTER, B CLEAR, F none
//   listo        in   consumer ready
//   dato_valido  out  number available, held until listo
//   numero_bcd   out  [4*N_DIG-1:0] packed BCD, newest digit in [3:0]
//   numero_bin   out  [W_BIN-1:0] binary value of numero_bcd
//   n_digitos    out  [2:0] digits entered so far
//   lleno        out  n_digitos == N_DIG
// -----------------------------------------------------------------------------
module captura_numero
   import teclado_pkg::*;
#(
   parameter int N_DIG       = 3,
   parameter int W_BIN       = 10,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           boton,
   input  logic                 listo,
   output logic                 dato_valido,
   output logic [4*N_DIG-1:0]   numero_bcd,
   output logic [W_BIN-1:0]     numero_bin,
   output logic [2:0]           n_digitos,
   output logic                 lleno
);

   // Elaboration-time sanity check of the configuration.
   generate
      if (N_DIG < 1 || N_DIG > 6 || W_BIN < 4 || TIMEOUT_CYC < 1) begin : g_param_invalido
         $error("captura_numero: invalid N_DIG, W_BIN or TIMEOUT_CYC");
      end
   endgenerate

   estado_captura_t estado;
   logic            evento;
   logic [3:0]      codigo;
   logic            timeout_hit;

   logic [4*N_DIG-1:0] bcd_next;
   logic [W_BIN-1:0]   bin_next;

   detector_tecla u_detector (
      .clk    (clk),
      .rst    (rst),
      .boton  (boton),
      .evento (evento),
      .codigo (codigo)
   );

   assign lleno = (n_digitos == 3'(N_DIG));

   // Appending a digit: shift one nibble left (oldest digit falls off the
   // top) and accumulate the binary value; both truncate naturally.
   assign bcd_next = (numero_bcd << 4) | (4*N_DIG)'(codigo);
   assign bin_next = (numero_bin * W_BIN'(10)) + W_BIN'(codigo);

`ifdef CAPTURA_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_inactivo;

   // Counts idle cycles only while a partial entry exists.
   assign timeout_hit = (estado == S_CAPTURA) && (n_digitos != 3'd0) && !evento &&
                        (cnt_inactivo == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_inactivo <= '0;
      end else if ((estado != S_CAPTURA) || (n_digitos == 3'd0) || evento || timeout_hit) begin
         cnt_inactivo <= '0;
      end else begin
         cnt_inactivo <= cnt_inactivo + CNT_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // FSM and datapath registers in one process; all outputs registered
   // except lleno.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado      <= S_CAPTURA;
         dato_valido <= 1'b0;
         numero_bcd  <= '0;
         numero_bin  <= '0;
         n_digitos   <= 3'd0;
      end else begin
         case (estado)
            S_CAPTURA: begin
               // listo is not looked at here: the handshake can only
               // complete once dato_valido is already high.
               if (evento) begin
                  if (es_digito(codigo)) begin
                     if (!lleno) begin
                        numero_bcd <= bcd_next;
                        numero_bin <= bin_next;
                        n_digitos  <= n_digitos + 3'd1;
                     end
                  end else if (codigo == TECLA_ENTER) begin
                     if (n_digitos != 3'd0) begin
                        estado      <= S_ENTREGA;
                        dato_valido <= 1'b1;
                     end
                  end else if (codigo == TECLA_CLEAR) begin
                     numero_bcd <= '0;
                     numero_bin <= '0;
                     n_digitos  <= 3'd0;
                  end
                  // C, D, E fall through unchanged.
               end else if (timeout_hit) begin
                  numero_bcd <= '0;
                  numero_bin <= '0;
                  n_digitos  <= 3'd0;
               end
            end

            S_ENTREGA: begin
               // Outputs frozen; key events are dropped here.
               if (listo) begin
                  estado      <= S_CAPTURA;
                  dato_valido <= 1'b0;
                  numero_bcd  <= '0;
                  numero_bin  <= '0;
                  n_digitos   <= 3'd0;
               end
            end

            default: begin
               estado      <= S_CAPTURA;
               dato_valido <= 1'b0;
            end
         endcase
      end
   end

endmodule : captura_numero

// File: tb/tb_captura_numero.sv
// -----------------------------------------------------------------------------
// tb_captura_numero
//   Directed bench for captura_numero (N_DIG=3, W_BIN=10, TIMEOUT_CYC=100).
//   Inputs change and outputs are sampled on the falling clock edge.
//   Submitted numbers are queued as expectations when ENTER is pressed and
//   compared when dato_valido is seen.
// -----------------------------------------------------------------------------
module tb_captura_numero;

   localparam int N_DIG       = 3;
   localparam int W_BIN       = 10;
   localparam int TIMEOUT_CYC = 100;

   typedef struct packed {
      logic [11:0] bcd;
      logic [9:0]  bin;
      logic [2:0]  n;
   } esperado_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [3:0]           boton;
   logic                 listo;
   logic                 dato_valido;
   logic [4*N_DIG-1:0]   numero_bcd;
   logic [W_BIN-1:0]     numero_bin;
   logic [2:0]           n_digitos;
   logic                 lleno;

   esperado_t sb[$];
   int n_vec = 0;
   int n_err = 0;

   captura_numero #(
      .N_DIG       (N_DIG),
      .W_BIN       (W_BIN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .boton       (boton),
      .listo       (listo),
      .dato_valido (dato_valido),
      .numero_bcd  (numero_bcd),
      .numero_bin  (numero_bin),
      .n_digitos   (n_digitos),
      .lleno       (lleno)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full press: code for two cycles (event + update), then release.
   task automatic pulsar(input logic [3:0] k);
      boton = k;
      repeat (2) @(negedge clk);
      boton = 4'hF;
      @(negedge clk);
   endtask

   task automatic ver_estado(input string tag, input logic dv, input logic [11:0] bcd,
                             input logic [9:0] bin, input logic [2:0] n);
      check({tag, ".dv"},  32'(dato_valido), 32'(dv));
      check({tag, ".bcd"}, 32'(numero_bcd),  32'(bcd));
      check({tag, ".bin"}, 32'(numero_bin),  32'(bin));
      check({tag, ".n"},   32'(n_digitos),   32'(n));
   endtask

   // Wait (bounded) for dato_valido, then compare against the oldest expectation.
   task automatic recibir(input string tag);
      esperado_t e;
      int espera = 0;
      while (!dato_valido && espera < 20) begin
         @(negedge clk);
         espera++;
      end
      check({tag, ".dv_seen"}, 32'(dato_valido), 32'd1);
      check({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, ".bcd"}, 32'(numero_bcd), 32'(e.bcd));
         check({tag, ".bin"}, 32'(numero_bin), 32'(e.bin));
         check({tag, ".n"},   32'(n_digitos),  32'(e.n));
      end
   endtask

   task automatic aceptar(input string tag);
      listo = 1'b1;
      @(negedge clk);
      listo = 1'b0;
      ver_estado({tag, ".after_listo"}, 1'b0, 12'h000, 10'd0, 3'd0);
   endtask

   initial begin
      rst   = 1'b0;
      boton = 4'hF;
      listo = 1'b0;

      // T1: reset values, then asynchronous reset in the middle of an entry.
      #12;
      ver_estado("t1_por", 1'b0, 12'h000, 10'd0, 3'd0);
      check("t1_por.lleno", 32'(lleno), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulsar(4'h1);
      pulsar(4'h2);
      ver_estado("t1_mid", 1'b0, 12'h012, 10'd12, 3'd2);
      #2 rst = 1'b0;
      #1 ver_estado("t1_async", 1'b0, 12'h000, 10'd0, 3'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // T2: 4,2,7 ENTER, then accept.
      pulsar(4'h4);
      pulsar(4'h2);
      pulsar(4'h7);
      check("t2.lleno", 32'(lleno), 32'd1);
      sb.push_back('{bcd: 12'h427, bin: 10'd427, n: 3'd3});
      pulsar(4'hA);
      recibir("t2");
      check("t2.lleno_frozen", 32'(lleno), 32'd1);
      aceptar("t2");

      // T3: overflow digit ignored.
      pulsar(4'h9);
      pulsar(4'h9);
      pulsar(4'h9);
      pulsar(4'h5);
      ver_estado("t3", 1'b0, 12'h999, 10'd999, 3'd3);
      check("t3.lleno", 32'(lleno), 32'd1);
      pulsar(4'hC);  // ignored code
      ver_estado("t3_codeC", 1'b0, 12'h999, 10'd999, 3'd3);
      pulsar(4'hB);
      ver_estado("t3_clear", 1'b0, 12'h000, 10'd0, 3'd0);

      // T4: 3, CLEAR, 8, ENTER; then ENTER alone.
      pulsar(4'h3);
      pulsar(4'hB);
      pulsar(4'h8);
      sb.push_back('{bcd: 12'h008, bin: 10'd8, n: 3'd1});
      pulsar(4'hA);
      recibir("t4");
      aceptar("t4");
      pulsar(4'hA);
      repeat (3) @(negedge clk);
      ver_estado("t4_enter_empty", 1'b0, 12'h000, 10'd0, 3'd0);

      // listo held while capturing, and together with the ENTER event.
      listo = 1'b1;
      pulsar(4'h4);
      ver_estado("t4_listo_capt", 1'b0, 12'h004, 10'd4, 3'd1);
      boton = 4'hA;
      repeat (2) @(negedge clk);
      ver_estado("t4_enter_listo", 1'b1, 12'h004, 10'd4, 3'd1);
      boton = 4'hF;
      @(negedge clk);
      ver_estado("t4_handshake", 1'b0, 12'h000, 10'd0, 3'd0);
      listo = 1'b0;
      @(negedge clk);

      // T5: held key, code change without release, keys during delivery.
      boton = 4'h6;
      repeat (1000) @(negedge clk);
      ver_estado("t5_hold", 1'b0, 12'h006, 10'd6, 3'd1);
      boton = 4'h1;
      repeat (5) @(negedge clk);
      ver_estado("t5_nogap", 1'b0, 12'h006, 10'd6, 3'd1);
      boton = 4'hF;
      repeat (2) @(negedge clk);
      pulsar(4'h2);
      sb.push_back('{bcd: 12'h062, bin: 10'd62, n: 3'd2});
      pulsar(4'hA);
      recibir("t5");
      pulsar(4'h3);
      pulsar(4'hB);
      pulsar(4'h5);
      ver_estado("t5_frozen", 1'b1, 12'h062, 10'd62, 3'd2);
      boton = 4'h7;  // held across the transfer
      repeat (2) @(negedge clk);
      aceptar("t5");
      repeat (5) @(negedge clk);
      ver_estado("t5_held_after", 1'b0, 12'h000, 10'd0, 3'd0);
      boton = 4'hF;
      repeat (2) @(negedge clk);

      // T6: idle behaviour with a partial entry and with none.
      pulsar(4'h5);
      repeat (90) @(negedge clk);
      ver_estado("t6_before", 1'b0, 12'h005, 10'd5, 3'd1);
      repeat (20) @(negedge clk);
`ifdef CAPTURA_TIMEOUT_EN
      ver_estado("t6_timeout", 1'b0, 12'h000, 10'd0, 3'd0);
`else
      ver_estado("t6_persist", 1'b0, 12'h005, 10'd5, 3'd1);
      pulsar(4'hB);
`endif
      repeat (150) @(negedge clk);
      ver_estado("t6_idle_empty", 1'b0, 12'h000, 10'd0, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_captura_numero
